// File: rtl/debug_io_monitor_if.sv
// debug_io_monitor_if: single-cycle request/valid read port for the debug I/O monitor
interface debug_io_monitor_if;
  logic        RD_REQ_I;
  logic [1:0]  RD_CH_I;
  logic [1:0]  RD_FIELD_I;
  logic        RD_VALID_O;
  logic [31:0] RD_DATA_O;
  modport master (output RD_REQ_I, RD_CH_I, RD_FIELD_I, input RD_VALID_O, RD_DATA_O);
  modport slave (input RD_REQ_I, RD_CH_I, RD_FIELD_I, output RD_VALID_O, RD_DATA_O);
endinterface

// File: rtl/debug_io_monitor.sv
// debug_io_monitor: per-line edge count, period, high time and liveness of a synchronized 4-bit debug bus
module debug_io_monitor #(
  parameter int CNT_W = 32,
  parameter int EDGE_W = 16,
  parameter int TIMEOUT = 100000000
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic [3:0]        DEBUG_I,
  input  logic              CLR_I,
  debug_io_monitor_if.slave rd,
  output logic [3:0]        ALIVE_O
);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_M2 = CNT_W'(TIMEOUT - 2);
  logic [3:0][3:0][31:0] fld;
  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic s1_q, s2_q, s3_q, seen_q, pvalid_q, hvalid_q, alive_q;
    logic s1_d, s2_d, s3_d, seen_d, pvalid_d, hvalid_d, alive_d;
    logic [CNT_W-1:0] run_q, high_q, idle_q, period_q, htime_q;
    logic [CNT_W-1:0] run_d, high_d, idle_d, period_d, htime_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic rise, fall;
    always_comb begin
      rise = s2_q & ~s3_q;
      fall = ~s2_q & s3_q;
      s1_d = DEBUG_I[c];
      s2_d = s1_q;
      s3_d = s2_q;
      run_d = CLR_I ? '0 : rise ? CNT_W'(1) : (&run_q) ? run_q : run_q + 1'b1;
      high_d = CLR_I ? '0 : rise ? CNT_W'(1) : (s2_q & ~&high_q) ? high_q + 1'b1 : high_q;
      idle_d = (CLR_I | rise) ? '0 : (idle_q == TO_M1) ? idle_q : idle_q + 1'b1;
      seen_d = ~CLR_I & (seen_q | rise);
      period_d = CLR_I ? '0 : (rise & seen_q) ? run_q : period_q;
      pvalid_d = ~CLR_I & (pvalid_q | (rise & seen_q));
      htime_d = CLR_I ? '0 : (fall & seen_q) ? high_q : htime_q;
      hvalid_d = ~CLR_I & (hvalid_q | (fall & seen_q));
      edge_d = CLR_I ? '0 : rise ? edge_q + 1'b1 : edge_q;
      alive_d = ~CLR_I & (rise | (alive_q & (idle_q != TO_M2)));
    end
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        s3_q <= 1'b0;
        seen_q <= 1'b0;
        pvalid_q <= 1'b0;
        hvalid_q <= 1'b0;
        alive_q <= 1'b0;
        run_q <= '0;
        high_q <= '0;
        idle_q <= '0;
        period_q <= '0;
        htime_q <= '0;
        edge_q <= '0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
        seen_q <= seen_d;
        pvalid_q <= pvalid_d;
        hvalid_q <= hvalid_d;
        alive_q <= alive_d;
        run_q <= run_d;
        high_q <= high_d;
        idle_q <= idle_d;
        period_q <= period_d;
        htime_q <= htime_d;
        edge_q <= edge_d;
      end
    end
    assign fld[c] = {{27'd0, s2_q, seen_q, hvalid_q, pvalid_q, alive_q}, 32'(htime_q), 32'(period_q), 32'(edge_q)};
    assign ALIVE_O[c] = alive_q;
  end
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  always_comb begin
    rd_valid_d = rd.RD_REQ_I;
    rd_data_d = rd.RD_REQ_I ? fld[rd.RD_CH_I][rd.RD_FIELD_I] : rd_data_q;
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign rd.RD_VALID_O = rd_valid_q;
  assign rd.RD_DATA_O = rd_data_q;
endmodule

// File: doc/debug_io_monitor.md
# debug_io_monitor

Receive-side counterpart to the debug I/O selector. It samples the 4-bit debug bus after the bus leaves the selector, looped back or fed from another board, and synchronizes each line. For every line it counts rising edges and measures period, high time and liveness. Results are read through a single-cycle request/valid port from the register-bank side on S_AXI_ACLK.

## Interface
Parameters:
- CNT_W, 32, width of period/high-time measurements (8..32)
- EDGE_W, 16, width of per-channel rising-edge counter
- TIMEOUT, 100000000, cycles without a rising edge before ALIVE clears (≥2, < 2^CNT_W)

Ports:
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESET  in  1  asynchronous, active-high reset
- DEBUG_I  in  4  debug lines, asynchronous to S_AXI_ACLK
- CLR_I  in  1  one-cycle pulse, clears all measurements and flags
- RD_REQ_I  in  1  read request, one cycle
- RD_CH_I  in  2  channel select 0..3
- RD_FIELD_I  in  2  0=EDGE_CNT, 1=PERIOD, 2=HIGH_TIME, 3=STATUS
- RD_VALID_O  out  1  one-cycle pulse, data valid
- RD_DATA_O  out  32  read data, zero-extended
- ALIVE_O  out  4  per-channel liveness flag

## Operation
- Per line: 2-FF synchronizer (s1, s2) plus history FF s3. Rise = s2 & ~s3. Fall = ~s2 & s3. All three FFs reset to 0.
- run_cnt (CNT_W): on rise ←1; otherwise +1, saturating at all-ones.
- On rise with seen=1: PERIOD ← run_cnt and pvalid ← 1. Every rise sets seen ← 1.
- high_cnt (CNT_W): on rise ←1; while s2=1 and no rise, +1 saturating. On fall with seen=1: HIGH_TIME ← high_cnt and hvalid ← 1.
- EDGE_CNT: +1 per rise, wraps modulo 2^EDGE_W.
- ALIVE: set on rise, and idle_cnt ← 0. Otherwise idle_cnt +1. When idle_cnt reaches TIMEOUT-1 with no rise, ALIVE ← 0 and idle_cnt holds. The flag clears exactly TIMEOUT cycles after the last rise cycle.
- STATUS word: bit0=ALIVE, bit1=pvalid, bit2=hvalid, bit3=seen, bit4=s2 (current level), rest 0.
- CLR_I clears run_cnt, high_cnt, idle_cnt, EDGE_CNT, PERIOD, HIGH_TIME, seen, pvalid, hvalid and ALIVE. Synchronizer FFs are untouched.
- CLR_I coinciding with a rise: clear wins and the edge is discarded. The next rise counts as the first, so seen is set but PERIOD is not updated.
- Read: RD_REQ_I sampled high → next cycle RD_VALID_O=1 and RD_DATA_O = selected field as of the request cycle, i.e. before any same-cycle update.
- Back-to-back requests are allowed, one result per cycle. RD_DATA_O holds its last value when RD_VALID_O=0.
- Read concurrent with CLR_I returns the pre-clear value.

## Timing
- Reset values: RD_VALID_O=0, RD_DATA_O=0, ALIVE_O=0. All internal counters and flags are 0.
- Reset is asynchronous assert. Deassertion is used as-is; the upstream reset source is already synchronized. Reset mid-measurement discards all state.
- Input latency: a DEBUG_I transition sampled at clock edge N gives s2 at N+1 and rise/fall during cycle N+1. Measurement registers update at edge N+2.
- Period/high resolution is ±1 cycle from synchronization. Saturated values read all-ones (truncated to CNT_W).
- Read latency is 1 cycle with no back-pressure.
- ALIVE_O is registered and equals the internal flag.

## Test plan
- Reset: hold S_AXI_ARESET 500 ns, 100 MHz clock → ALIVE_O=0, RD_VALID_O=0. Reading every channel/field returns 0.
- Square wave on DEBUG_I[0], 200 ns period, 60 ns high, 10 edges → EDGE_CNT=10, PERIOD=20, HIGH_TIME=6, STATUS[3:0]=4'b1111. Channels 1..3 read EDGE_CNT=0.
- Liveness (TIMEOUT=50): pulse DEBUG_I[2] once then hold low → ALIVE_O[2]=1 from 2 cycles after the edge. It drops exactly 50 cycles after the rise cycle. PERIOD reads 0 and pvalid=0.
- All four lines toggle with periods 10/20/30/40 cycles and RD_REQ_I is held high for 4 cycles cycling the channel → four consecutive RD_VALID_O pulses with PERIOD 10, 20, 30, 40.
- Issue CLR_I in the same cycle as a detected rise on DEBUG_I[1] → EDGE_CNT=0 and ALIVE_O[1]=0 afterwards. The following two rises 16 cycles apart give EDGE_CNT=2 and PERIOD=16.
- EDGE_W=4: 17 rises → EDGE_CNT=1 (wrap). With CNT_W=8, hold DEBUG_I[3] high 300 cycles → HIGH_TIME=255 (saturated).
